// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared FSM state type, polynomial constants and CRC step function
// Purpose: common definitions for the serial CRC codec.
//   state_t    : codec frame FSM states (IDLE, SHIFT, DONE)
//   CRC3_POLY  : x^3 + x + 1 low terms
//   CRC8_POLY  : x^8 + x^2 + x + 1 low terms
//   crc_step() : one direct-form LFSR update for a register of up to CRC_MAX bits
package crc_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam int CRC_MAX = 32;
   typedef logic [CRC_MAX-1:0] crc_word_t;

   localparam logic [2:0] CRC3_POLY = 3'b011;
   localparam logic [7:0] CRC8_POLY = 8'h07;

   // Direct-form update: the incoming bit is folded into the register MSB, so
   // no trailing zero-padding cycles are needed to finish the division.
   // Only the low 'width' bits of crc/poly are meaningful.
   function automatic crc_word_t crc_step(input crc_word_t   crc,
                                          input logic        din,
                                          input crc_word_t   poly,
                                          input int unsigned width);
      crc_word_t  mask;
      logic [4:0] msb;
      logic       fb;
      msb  = 5'(width - 1);
      // width == CRC_MAX wraps the shift to zero, giving an all-ones mask
      mask = (crc_word_t'(1) << width) - crc_word_t'(1);
      fb   = din ^ crc[msb];
      return ((crc << 1) ^ (fb ? poly : '0)) & mask;
   endfunction

endpackage

// File: rtl/crc_lfsr.sv
// rtl/crc_lfsr.sv - CRC remainder register with load-INIT / step / hold control
// Purpose: holds the running CRC for one frame; sequencing is owned by the codec FSM.
// Ports:
//   gated_clk  in   gated clock, all state on posedge
//   reset      in   async active-high, register -> INIT
//   load       in   reload INIT (frame start / abandon); wins over step
//   step       in   fold din into the register
//   din        in   serial data bit
//   crc        out  current register value
//   crc_next   out  value the register takes if stepped with din this cycle
module crc_lfsr
   import crc_pkg::*;
#(
   parameter int               CRC_W = 3,
   parameter logic [CRC_W-1:0] POLY  = CRC3_POLY,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic             gated_clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             din,
   output logic [CRC_W-1:0] crc,
   output logic [CRC_W-1:0] crc_next
);

   assign crc_next = CRC_W'(crc_step(crc_word_t'(crc), din, crc_word_t'(POLY), CRC_W));

   always_ff @(posedge gated_clk or posedge reset) begin
      if (reset) begin
         crc <= INIT;
      end else if (load) begin
         crc <= INIT;
      end else if (step) begin
         crc <= crc_next;
      end
   end

endmodule

// File: rtl/crc_serial_codec.sv
// rtl/crc_serial_codec.sv - serial-in CRC encoder (optional checker) with parallel codeword out
// Purpose: shifts in an MSG_W-bit message MSB-first, divides it by x^CRC_W + POLY and
//   presents {msg, crc} until the consumer takes it.
// Optional feature macro: CRC_CHECK_EN (adds mode / crc_err; mode=1 checks a received
//   MSG_W+CRC_W-bit codeword through the same LFSR).
// Ports:
//   gated_clk  in   gated clock, all state on posedge
//   reset      in   async active-high
//   abort      in   sync frame abandon, any state -> IDLE
//   in_valid   in   serial bit valid
//   in_bit     in   serial data, MSB-first
//   in_ready   out  bit accepted this cycle when in_valid is high
//   out_valid  out  codeword available
//   out_ready  in   consumer takes codeword
//   codeword   out  {msg, crc} (check mode: last MSG_W+CRC_W received bits); 0 unless out_valid
//   busy       out  frame in progress
//   mode       in   (CRC_CHECK_EN) 1 = check frame, sampled on the first accepted bit
//   crc_err    out  (CRC_CHECK_EN) check frame remainder non-zero, valid in DONE
module crc_serial_codec
   import crc_pkg::*;
#(
   parameter int               CRC_W = 3,
   parameter int               MSG_W = 5,
   parameter logic [CRC_W-1:0] POLY  = CRC3_POLY,
   parameter logic [CRC_W-1:0] INIT  = '0
) (
   input  logic                   gated_clk,
   input  logic                   reset,
   input  logic                   abort,
   input  logic                   in_valid,
   input  logic                   in_bit,
   output logic                   in_ready,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [MSG_W+CRC_W-1:0] codeword,
   output logic                   busy
`ifdef CRC_CHECK_EN
   ,
   input  logic                   mode,
   output logic                   crc_err
`endif
);

   localparam int CW_W = MSG_W + CRC_W;
`ifdef CRC_CHECK_EN
   // check frames keep the whole received codeword
   localparam int SR_W = MSG_W + CRC_W;
`else
   localparam int SR_W = MSG_W;
`endif
   localparam int CNT_W = $clog2(SR_W + 1);

   state_t           state;
   logic [SR_W-1:0]  msg;
   logic [CNT_W-1:0] cnt;
   logic [CRC_W-1:0] crc;
   logic [CRC_W-1:0] crc_next;
   logic [SR_W-1:0]  msg_next;
   logic [CW_W-1:0]  cw_next;
   logic [CNT_W-1:0] last_cnt;
   logic             frame_mode;
   logic             accept;
   logic             last_accept;
   logic             release_cw;
   logic             crc_load;

   // abort outranks everything, so a bit presented alongside it is dropped
   assign accept      = in_valid & in_ready & ~abort;
   assign last_cnt    = frame_mode ? CNT_W'(SR_W - 1) : CNT_W'(MSG_W - 1);
   // cnt is 0 in IDLE, so a one-bit frame finishes on its first accept
   assign last_accept = accept & (cnt == last_cnt);
   assign release_cw  = (state == DONE) & out_ready & ~abort;
   assign crc_load    = abort | release_cw;
   assign msg_next    = SR_W'({msg, in_bit});

`ifdef CRC_CHECK_EN
   logic mode_q;

   // mode is only live on the first bit; afterwards the latched copy governs
   assign frame_mode = (state == IDLE) ? mode : mode_q;
   assign cw_next    = frame_mode ? msg_next : {msg_next[MSG_W-1:0], crc_next};

   always_ff @(posedge gated_clk or posedge reset) begin
      if (reset) begin
         mode_q  <= 1'b0;
         crc_err <= 1'b0;
      end else if (abort) begin
         crc_err <= 1'b0;
      end else begin
         if (accept && (state == IDLE)) begin
            mode_q <= mode;
         end
         // a clean codeword leaves a zero remainder after all its bits
         if (last_accept) begin
            crc_err <= frame_mode & (crc_next != '0);
         end else if (release_cw) begin
            crc_err <= 1'b0;
         end
      end
   end
`else
   assign frame_mode = 1'b0;
   assign cw_next    = {msg_next, crc_next};
`endif

   crc_lfsr #(
      .CRC_W (CRC_W),
      .POLY  (POLY),
      .INIT  (INIT)
   ) u_lfsr (
      .gated_clk (gated_clk),
      .reset     (reset),
      .load      (crc_load),
      .step      (accept),
      .din       (in_bit),
      .crc       (crc),
      .crc_next  (crc_next)
   );

   always_ff @(posedge gated_clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         msg       <= '0;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         codeword  <= '0;
         busy      <= 1'b0;
      end else if (abort) begin
         state     <= IDLE;
         cnt       <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         codeword  <= '0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE, SHIFT: begin
               if (accept) begin
                  msg  <= msg_next;
                  cnt  <= cnt + CNT_W'(1);
                  busy <= 1'b1;
                  if (last_accept) begin
                     // capture from next-state values so out_valid rises one cycle after the last bit
                     state     <= DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                     codeword  <= cw_next;
                  end else begin
                     state <= SHIFT;
                  end
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  cnt       <= '0;
                  in_ready  <= 1'b1;
                  out_valid <= 1'b0;
                  codeword  <= '0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_crc_serial_codec.sv
// tb/tb_crc_serial_codec.sv - self-checking bench for crc_serial_codec (CRC-3 and CRC-8 instances)
// Purpose: drives serial frames into a default CRC-3 instance (a_*) and a CRC-8/0x07
//   instance (b_*), comparing against a polynomial long-division reference model.
//   Check-mode scenarios run when CRC_CHECK_EN is defined.
module tb_crc_serial_codec;
   import crc_pkg::*;

   logic gated_clk = 1'b0;
   logic reset     = 1'b1;
   always #5 gated_clk = ~gated_clk;

   int checks = 0;
   int errors = 0;

   logic       a_abort = 0, a_in_valid = 0, a_in_bit = 0, a_out_ready = 0;
   logic       a_in_ready, a_out_valid, a_busy;
   logic [7:0] a_codeword;
   logic       b_abort = 0, b_in_valid = 0, b_in_bit = 0, b_out_ready = 0;
   logic       b_in_ready, b_out_valid, b_busy;
   logic [15:0] b_codeword;
`ifdef CRC_CHECK_EN
   logic a_mode = 0, b_mode = 0;
   logic a_crc_err, b_crc_err;
`endif

   crc_serial_codec u_a (
      .gated_clk (gated_clk), .reset (reset), .abort (a_abort),
      .in_valid (a_in_valid), .in_bit (a_in_bit), .in_ready (a_in_ready),
      .out_valid (a_out_valid), .out_ready (a_out_ready), .codeword (a_codeword),
      .busy (a_busy)
`ifdef CRC_CHECK_EN
      , .mode (a_mode), .crc_err (a_crc_err)
`endif
   );

   crc_serial_codec #(.CRC_W(8), .MSG_W(8), .POLY(CRC8_POLY), .INIT(8'h00)) u_b (
      .gated_clk (gated_clk), .reset (reset), .abort (b_abort),
      .in_valid (b_in_valid), .in_bit (b_in_bit), .in_ready (b_in_ready),
      .out_valid (b_out_valid), .out_ready (b_out_ready), .codeword (b_codeword),
      .busy (b_busy)
`ifdef CRC_CHECK_EN
      , .mode (b_mode), .crc_err (b_crc_err)
`endif
   );

   // Reference: remainder of val(x) * x^n divided by x^n + poly, by long division.
   function automatic longint unsigned ref_rem(input longint unsigned val, input int vbits,
                                               input int n, input longint unsigned poly);
      longint unsigned g, v;
      g = (64'd1 << n) | poly;
      v = val << n;
      for (int i = vbits + n - 1; i >= n; i--)
         if (v[i]) v = v ^ (g << (i - n));
      return v & ((64'd1 << n) - 64'd1);
   endfunction

   function automatic logic [15:0] ref_cw(input int sel, input longint unsigned msg);
      if (sel == 0) return 16'((msg << 3) | ref_rem(msg, 5, 3, 64'h3));
      return 16'((msg << 8) | ref_rem(msg, 8, 8, 64'h07));
   endfunction

   function automatic logic get_ready(input int sel);
      return (sel == 0) ? a_in_ready : b_in_ready;
   endfunction
   function automatic logic get_ov(input int sel);
      return (sel == 0) ? a_out_valid : b_out_valid;
   endfunction
   function automatic logic [15:0] get_cw(input int sel);
      return (sel == 0) ? {8'h00, a_codeword} : b_codeword;
   endfunction
   function automatic logic get_busy(input int sel);
      return (sel == 0) ? a_busy : b_busy;
   endfunction

   task automatic set_in(input int sel, input logic v, input logic b);
      if (sel == 0) begin a_in_valid = v; a_in_bit = b; end
      else          begin b_in_valid = v; b_in_bit = b; end
   endtask

   task automatic set_or(input int sel, input logic v);
      if (sel == 0) a_out_ready = v; else b_out_ready = v;
   endtask

   // Presents bits[len-1:0] MSB-first; returns at the negedge after the last accept.
   task automatic send_bits(input int sel, input logic [15:0] bits, input int len, input bit gaps);
      for (int i = len - 1; i >= 0; i--) begin
         if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin @(negedge gated_clk); set_in(sel, 1'b0, 1'($urandom)); end
         end
         @(negedge gated_clk);
         begin
            int w;
            w = 0;
            while (!get_ready(sel) && w < 50) begin @(negedge gated_clk); w++; end
            checks++;
            if (w == 50) begin
               errors++;
               $display("FAIL in_ready_wait sel=%0d: in_ready=0 for %0d cycles, required 1", sel, w);
            end
         end
         checks++;
         if (get_ov(sel) !== 1'b0) begin
            errors++;
            $display("FAIL early_out_valid sel=%0d bit=%0d: got %b, required 0", sel, i, get_ov(sel));
         end
         set_in(sel, 1'b1, bits[i]);
      end
      @(negedge gated_clk);
      set_in(sel, 1'b0, 1'($urandom));
   endtask

   // One-cycle handshake; returns at the following negedge.
   task automatic take(input int sel);
      set_or(sel, 1'b1);
      @(negedge gated_clk);
      set_or(sel, 1'b0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge gated_clk);
      checks++;
      if ({a_in_ready, a_out_valid, a_busy, a_codeword} !== {3'b100, 8'h00}) begin
         errors++;
         $display("FAIL reset_a: rdy/ov/busy/cw=%b%b%b/%h, required 100/00", a_in_ready, a_out_valid, a_busy, a_codeword);
      end
      checks++;
      if ({b_in_ready, b_out_valid, b_busy, b_codeword} !== {3'b100, 16'h0000}) begin
         errors++;
         $display("FAIL reset_b: rdy/ov/busy/cw=%b%b%b/%h, required 100/0000", b_in_ready, b_out_valid, b_busy, b_codeword);
      end
      reset = 1'b0;
      @(negedge gated_clk);
   endtask

   task automatic test_basic();
      send_bits(0, 16'b10110, 5, 1'b0);
      checks++;
      if ({a_out_valid, a_in_ready, a_busy, a_codeword} !== {3'b101, 8'hB0}) begin
         errors++;
         $display("FAIL basic_done: ov/rdy/busy/cw=%b%b%b/%h, required 101/b0", a_out_valid, a_in_ready, a_busy, a_codeword);
      end
      take(0);
      checks++;
      if ({a_out_valid, a_in_ready, a_busy, a_codeword} !== {3'b010, 8'h00}) begin
         errors++;
         $display("FAIL basic_idle: ov/rdy/busy/cw=%b%b%b/%h, required 010/00", a_out_valid, a_in_ready, a_busy, a_codeword);
      end
   endtask

   task automatic test_backpressure();
      send_bits(0, 16'b11001, 5, 1'b1);
      for (int c = 0; c < 4; c++) begin
         checks++;
         if ({a_out_valid, a_codeword} !== {1'b1, 8'hCF}) begin
            errors++;
            $display("FAIL hold_cycle%0d: ov/cw=%b/%h, required 1/cf", c, a_out_valid, a_codeword);
         end
         @(negedge gated_clk);
      end
      take(0);
      checks++;
      if ({a_busy, a_in_ready, a_out_valid} !== 3'b010) begin
         errors++;
         $display("FAIL hold_release: busy/rdy/ov=%b%b%b, required 010", a_busy, a_in_ready, a_out_valid);
      end
   endtask

   task automatic test_abort();
      send_bits(0, 16'b101, 3, 1'b0);
      a_abort = 1'b1;
      set_in(0, 1'b1, 1'b1);
      @(negedge gated_clk);
      a_abort = 1'b0;
      set_in(0, 1'b0, 1'b0);
      checks++;
      if ({a_busy, a_in_ready, a_out_valid} !== 3'b010) begin
         errors++;
         $display("FAIL abort_shift: busy/rdy/ov=%b%b%b, required 010", a_busy, a_in_ready, a_out_valid);
      end
      send_bits(0, 16'b10110, 5, 1'b0);
      checks++;
      if (a_codeword !== 8'hB0) begin
         errors++;
         $display("FAIL abort_residue: cw=%h, required b0", a_codeword);
      end
      // abort while the codeword waits drops it without a handshake
      a_abort = 1'b1;
      @(negedge gated_clk);
      a_abort = 1'b0;
      checks++;
      if ({a_out_valid, a_busy, a_codeword} !== {2'b00, 8'h00}) begin
         errors++;
         $display("FAIL abort_done: ov/busy/cw=%b%b/%h, required 00/00", a_out_valid, a_busy, a_codeword);
      end
      // asynchronous reset mid-frame
      send_bits(0, 16'b11, 2, 1'b0);
      checks++;
      if (a_busy !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_busy: got %b, required 1", a_busy);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if ({a_busy, a_in_ready, a_out_valid, a_codeword} !== {3'b010, 8'h00}) begin
         errors++;
         $display("FAIL midframe_reset: busy/rdy/ov/cw=%b%b%b/%h, required 010/00", a_busy, a_in_ready, a_out_valid, a_codeword);
      end
      @(negedge gated_clk);
      reset = 1'b0;
      send_bits(0, 16'b11001, 5, 1'b0);
      checks++;
      if (a_codeword !== 8'hCF) begin
         errors++;
         $display("FAIL post_reset_frame: cw=%h, required cf", a_codeword);
      end
      take(0);
   endtask

   task automatic test_done_ignores();
      send_bits(0, 16'b10110, 5, 1'b0);
      for (int c = 0; c < 3; c++) begin
         set_in(0, 1'b1, 1'($urandom));
         @(negedge gated_clk);
         checks++;
         if ({a_in_ready, a_codeword} !== {1'b0, 8'hB0}) begin
            errors++;
            $display("FAIL done_ignore%0d: rdy/cw=%b/%h, required 0/b0", c, a_in_ready, a_codeword);
         end
      end
      // bit still offered during the handshake cycle must not start a frame
      set_in(0, 1'b1, 1'b1);
      take(0);
      set_in(0, 1'b0, 1'b0);
      checks++;
      if ({a_busy, a_in_ready} !== 2'b01) begin
         errors++;
         $display("FAIL no_overlap: busy/rdy=%b%b, required 01", a_busy, a_in_ready);
      end
      send_bits(0, 16'b11001, 5, 1'b1);
      checks++;
      if (a_codeword !== 8'hCF) begin
         errors++;
         $display("FAIL after_done_frame: cw=%h, required cf", a_codeword);
      end
      take(0);
   endtask

   task automatic test_random(input int sel, input int nframes);
      int len;
      len = (sel == 0) ? 5 : 8;
      for (int f = 0; f < nframes; f++) begin
         logic [15:0] m, exp;
         int hold;
         m    = 16'($urandom_range(0, (1 << len) - 1));
         exp  = ref_cw(sel, 64'(m));
         send_bits(sel, m, len, 1'($urandom));
         hold = $urandom_range(0, 2);
         repeat (hold) @(negedge gated_clk);
         checks++;
         if ({get_ov(sel), get_cw(sel)} !== {1'b1, exp}) begin
            errors++;
            $display("FAIL random sel=%0d msg=%h: ov/cw=%b/%h, required 1/%h", sel, m, get_ov(sel), get_cw(sel), exp);
         end
         take(sel);
         checks++;
         if (get_busy(sel) !== 1'b0) begin
            errors++;
            $display("FAIL random_release sel=%0d: busy=%b, required 0", sel, get_busy(sel));
         end
      end
   endtask

   task automatic test_crc8();
      send_bits(1, 16'h0031, 8, 1'b0);
      checks++;
      if ({b_out_valid, b_codeword} !== {1'b1, 16'h3197}) begin
         errors++;
         $display("FAIL crc8_0x31: ov/cw=%b/%h, required 1/3197", b_out_valid, b_codeword);
      end
      take(1);
      test_random(1, 20);
      test_random(0, 10);
   endtask

`ifdef CRC_CHECK_EN
   task automatic test_check_mode();
      a_mode = 1'b1;
      send_bits(0, 16'hCF, 8, 1'b0);
      checks++;
      if ({a_out_valid, a_crc_err, a_codeword} !== {2'b10, 8'hCF}) begin
         errors++;
         $display("FAIL check_good: ov/err/cw=%b%b/%h, required 10/cf", a_out_valid, a_crc_err, a_codeword);
      end
      take(0);
      send_bits(0, 16'hCE, 8, 1'b1);
      checks++;
      if ({a_out_valid, a_crc_err, a_codeword} !== {2'b11, 8'hCE}) begin
         errors++;
         $display("FAIL check_bad: ov/err/cw=%b%b/%h, required 11/ce", a_out_valid, a_crc_err, a_codeword);
      end
      take(0);
      a_mode = 1'b0;
      send_bits(0, 16'b10110, 5, 1'b0);
      checks++;
      if ({a_out_valid, a_crc_err, a_codeword} !== {2'b10, 8'hB0}) begin
         errors++;
         $display("FAIL encode_after_check: ov/err/cw=%b%b/%h, required 10/b0", a_out_valid, a_crc_err, a_codeword);
      end
      take(0);
      b_mode = 1'b1;
      for (int f = 0; f < 10; f++) begin
         logic [15:0] cw;
         logic        exp_err;
         cw = ref_cw(1, 64'($urandom_range(0, 255)));
         if ($urandom_range(0, 1) == 1) cw[$urandom_range(0, 15)] ^= 1'b1;
         exp_err = (ref_rem(64'(cw), 16, 8, 64'h07) != 0);
         send_bits(1, cw, 16, 1'($urandom));
         checks++;
         if ({b_crc_err, b_codeword} !== {exp_err, cw}) begin
            errors++;
            $display("FAIL check_random: err/cw=%b/%h, required %b/%h", b_crc_err, b_codeword, exp_err, cw);
         end
         take(1);
      end
      b_mode = 1'b0;
   endtask
`endif

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_abort();
      test_done_ignores();
      test_crc8();
`ifdef CRC_CHECK_EN
      test_check_mode();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
